// File: rtl/vlogic_pkg.sv
// Shared definitions for the multi-lane vector logic/compare unit: opcode and escape
// encodings, control states and the IEEE-754 single-precision ordering helpers.
package vlogic_pkg;

    typedef enum logic [4:0] {
        OP_EQ     = 5'd0,
        OP_NE     = 5'd1,
        OP_LTU    = 5'd2,
        OP_SLL    = 5'd3,
        OP_SRL    = 5'd4,
        OP_SRA    = 5'd5,
        OP_XOR    = 5'd6,
        OP_OR     = 5'd7,
        OP_AND    = 5'd8,
        OP_FSGNJ  = 5'd9,
        OP_FSGNJN = 5'd10,
        OP_FSGNJX = 5'd11,
        OP_MXOR   = 5'd12,
        OP_MOR    = 5'd13,
        OP_MAND   = 5'd14,
        OP_VID    = 5'd15,
        OP_VCPOP  = 5'd16,
        OP_VFIRST = 5'd17,
        OP_LT     = 5'd18,
        OP_LE     = 5'd19
    } op_e;

    // cont_esc: 0x = vector-vector, 10 = arg1 replaced by scalar, 11 = arg2 replaced by scalar
    localparam logic [1:0] ESC_ARG1 = 2'b10;
    localparam logic [1:0] ESC_ARG2 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
    endfunction

    // a < b; NaN never orders, and +0 / -0 compare equal
    function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
        logic [30:0] ma;
        logic [30:0] mb;
        ma = a[30:0];
        mb = b[30:0];
        if (fp_is_nan(a) || fp_is_nan(b)) return 1'b0;
        if (ma == 31'd0 && mb == 31'd0)   return 1'b0;
        if (a[31] != b[31])               return a[31];
        if (a[31])                        return ma > mb;
        return ma < mb;
    endfunction

endpackage

// File: rtl/vlogic_lane.sv
// Combinational single-element ALU: result = a2 OP a1. Reduction and VID ops yield 0 here;
// the top assembles those results itself.
module vlogic_lane
    import vlogic_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  op_e                   op,
    input  logic                  float_op,
    input  logic [DATA_WIDTH-1:0] a1,
    input  logic [DATA_WIDTH-1:0] a2,
    output logic [DATA_WIDTH-1:0] res
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic signed [DATA_WIDTH-1:0] s1;
    logic signed [DATA_WIDTH-1:0] s2;
    logic        [SHW-1:0]        sh;
    logic        [31:0]           f1;
    logic        [31:0]           f2;
    logic                         fp_ok;
    logic                         fp_lt_res;
    logic                         fp_le_res;

    assign s1 = signed'(a1);
    assign s2 = signed'(a2);
    assign sh = a1[SHW-1:0];
    assign f1 = 32'(a1);
    assign f2 = 32'(a2);

    // Float compares are only defined for single-precision elements
    assign fp_ok     = (DATA_WIDTH == 32);
    assign fp_lt_res = fp_ok && fp_lt(f2, f1);
    assign fp_le_res = fp_ok && !fp_is_nan(f1) && !fp_is_nan(f2) && !fp_lt(f1, f2);

    always_comb begin
        res = '0;
        case (op)
            OP_EQ:     res = DATA_WIDTH'(a2 == a1);
            OP_NE:     res = DATA_WIDTH'(a2 != a1);
            OP_LTU:    res = DATA_WIDTH'(a2 < a1);
            OP_LT:     res = float_op ? DATA_WIDTH'(fp_lt_res) : DATA_WIDTH'(s2 < s1);
            OP_LE:     res = float_op ? DATA_WIDTH'(fp_le_res) : DATA_WIDTH'(s2 <= s1);
            OP_SLL:    res = a2 << sh;
            OP_SRL:    res = a2 >> sh;
            OP_SRA:    res = $unsigned(s2 >>> sh);
            OP_XOR,
            OP_MXOR:   res = a2 ^ a1;
            OP_OR,
            OP_MOR:    res = a2 | a1;
            OP_AND,
            OP_MAND:   res = a2 & a1;
            OP_FSGNJ:  res = {a1[DATA_WIDTH-1], a2[DATA_WIDTH-2:0]};
            OP_FSGNJN: res = {~a1[DATA_WIDTH-1], a2[DATA_WIDTH-2:0]};
            OP_FSGNJX: res = {a1[DATA_WIDTH-1] ^ a2[DATA_WIDTH-1], a2[DATA_WIDTH-2:0]};
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/vec_logic_lanes.sv
// Multi-lane vector logic/compare operator: LANES elements per beat through a SEGMENTS-deep
// stallable pipeline, with element masks, tail handling, VID and VCPOP/VFIRST reductions.
module vec_logic_lanes
    import vlogic_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MVL        = 16,
    parameter int LANES      = 4,
    parameter int SEGMENTS   = 4,
    parameter int ID         = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  op_e                         op,
    input  logic                        float_op,
    input  logic [1:0]                  cont_esc,
    input  logic [DATA_WIDTH-1:0]       op_esc,
    input  logic [MVL-1:0]              mask,
    input  logic [$clog2(MVL):0]        vlr,
    input  logic                        arg_valid,
    output logic                        arg_ready,
    input  logic [LANES*DATA_WIDTH-1:0] arg1,
    input  logic [LANES*DATA_WIDTH-1:0] arg2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_mask,
    output logic                        out_last,
    output logic                        busy
);

    localparam int EW = $clog2(MVL) + 1;
    localparam int BW = $clog2(MVL / LANES) + 1;
    localparam int LW = LANES * DATA_WIDTH;

    // Elaborates only for an illegal configuration; the instance id itself is debug-only
    if (SEGMENTS < 1 || DATA_WIDTH < 8 || (MVL % LANES) != 0 || ID < 0) begin : g_bad_cfg
    end

    state_e                state_q;
    state_e                state_d;
    op_e                   op_q;
    logic                  float_q;
    logic [1:0]            esc_q;
    logic [DATA_WIDTH-1:0] scalar_q;
    logic [MVL-1:0]        mask_q;
    logic [EW-1:0]         vlr_q;
    logic [BW-1:0]         beats_q;
    logic [BW-1:0]         issued_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic                  found_q;
    logic [DATA_WIDTH-1:0] first_q;

    logic                  stall;
    logic                  is_vid;
    logic                  is_red;
    logic                  can_issue;
    logic                  issue;
    logic                  last_issue;
    logic [BW-1:0]         beats_d;
    logic [EW-1:0]         base;
    logic [LANES-1:0]      mask_win;

    logic [DATA_WIDTH-1:0] a1_l  [LANES];
    logic [DATA_WIDTH-1:0] a2_l  [LANES];
    logic [DATA_WIDTH-1:0] res_l [LANES];
    logic [EW-1:0]         elem  [LANES];
    logic [LANES-1:0]      tail;
    logic [LANES-1:0]      live;
    logic [LANES-1:0]      hit;
    logic [LW-1:0]         ew_data;

    logic [DATA_WIDTH-1:0] beat_cnt;
    logic [DATA_WIDTH-1:0] beat_first;
    logic                  beat_hit;
    logic [DATA_WIDTH-1:0] acc_d;
    logic                  found_d;
    logic [DATA_WIDTH-1:0] first_d;
    logic [DATA_WIDTH-1:0] red_val;

    logic [LW-1:0]         s0_data;
    logic [LANES-1:0]      s0_mask;
    logic                  s0_vld;

    logic [LW-1:0]         data_p [SEGMENTS];
    logic [LANES-1:0]      mask_p [SEGMENTS];
    logic [SEGMENTS-1:0]   last_p;
    logic [SEGMENTS-1:0]   vld_p;

    assign busy       = (state_q != ST_IDLE);
    assign stall      = out_valid && !out_ready;
    assign is_vid     = (op_q == OP_VID);
    assign is_red     = (op_q == OP_VCPOP) || (op_q == OP_VFIRST);
    assign can_issue  = busy && !stall && (issued_q < beats_q);
    // VID generates its own elements and never pops operands
    assign arg_ready  = can_issue && !is_vid;
    assign issue      = can_issue && (is_vid || arg_valid);
    assign last_issue = issue && (issued_q == beats_q - BW'(1));
    assign beats_d    = BW'((int'(vlr) + LANES - 1) / LANES);

    assign base     = EW'(issued_q) * EW'(LANES);
    assign mask_win = LANES'(mask_q >> base);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign elem[k] = base + EW'(k);
        assign tail[k] = (elem[k] >= vlr_q);
        assign live[k] = mask_win[k] && !tail[k];
        assign a1_l[k] = (esc_q == ESC_ARG1) ? scalar_q : arg1[k*DATA_WIDTH +: DATA_WIDTH];
        assign a2_l[k] = (esc_q == ESC_ARG2) ? scalar_q : arg2[k*DATA_WIDTH +: DATA_WIDTH];
        assign hit[k]  = live[k] && a2_l[k][0];

        vlogic_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .op       (op_q),
            .float_op (float_q),
            .a1       (a1_l[k]),
            .a2       (a2_l[k]),
            .res      (res_l[k])
        );

        assign ew_data[k*DATA_WIDTH +: DATA_WIDTH] =
            tail[k] ? '0 : (is_vid ? DATA_WIDTH'(elem[k]) : res_l[k]);
    end

    // Reduction view of the current beat merged with the running accumulators
    always_comb begin
        beat_cnt   = '0;
        beat_first = '1;
        beat_hit   = 1'b0;
        for (int k = LANES - 1; k >= 0; k--) begin
            beat_cnt = beat_cnt + DATA_WIDTH'(hit[k]);
            if (hit[k]) begin
                beat_hit   = 1'b1;
                beat_first = DATA_WIDTH'(elem[k]);
            end
        end
        acc_d   = acc_q + beat_cnt;
        found_d = found_q || beat_hit;
        first_d = found_q ? first_q : beat_first;
        red_val = (op_q == OP_VCPOP) ? acc_d : first_d;
    end

    // Reductions only emit on their final accepted beat
    assign s0_data = is_red ? LW'(red_val) : ew_data;
    assign s0_mask = is_red ? LANES'(1) : live;
    assign s0_vld  = issue && (!is_red || last_issue);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start && vlr != '0) state_d = ST_RUN;
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (out_valid && out_ready && out_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_EQ;
            float_q  <= 1'b0;
            esc_q    <= 2'b00;
            scalar_q <= '0;
            mask_q   <= '0;
            vlr_q    <= '0;
            beats_q  <= '0;
            issued_q <= '0;
            acc_q    <= '0;
            found_q  <= 1'b0;
            first_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start && state_q == ST_IDLE) begin
                op_q     <= op;
                float_q  <= float_op;
                esc_q    <= cont_esc;
                scalar_q <= op_esc;
                mask_q   <= mask;
                vlr_q    <= vlr;
                beats_q  <= beats_d;
                issued_q <= '0;
                acc_q    <= '0;
                found_q  <= 1'b0;
                first_q  <= '1;
            end else if (issue) begin
                issued_q <= issued_q + BW'(1);
                acc_q    <= acc_d;
                found_q  <= found_d;
                first_q  <= first_d;
            end
        end
    end

    // Stage 0 captures the accepted beat; later stages shift; a stall freezes every stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p  <= '0;
            last_p <= '0;
            for (int s = 0; s < SEGMENTS; s++) begin
                data_p[s] <= '0;
                mask_p[s] <= '0;
            end
        end else if (!stall) begin
            vld_p[0]  <= s0_vld;
            last_p[0] <= last_issue;
            data_p[0] <= s0_data;
            mask_p[0] <= s0_mask;
            for (int s = 1; s < SEGMENTS; s++) begin
                vld_p[s]  <= vld_p[s-1];
                last_p[s] <= last_p[s-1];
                data_p[s] <= data_p[s-1];
                mask_p[s] <= mask_p[s-1];
            end
        end
    end

    assign out_valid = vld_p[SEGMENTS-1];
    assign out_last  = last_p[SEGMENTS-1];
    assign out_data  = data_p[SEGMENTS-1];
    assign out_mask  = mask_p[SEGMENTS-1];

endmodule

// File: tb/tb_vec_logic_lanes.sv
// Directed bench for vec_logic_lanes with DATA_WIDTH=32, MVL=16, LANES=4, SEGMENTS=4.
module tb_vec_logic_lanes;
    import vlogic_pkg::*;

    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    op_e          op;
    logic         float_op;
    logic [1:0]   cont_esc;
    logic [31:0]  op_esc;
    logic [15:0]  mask;
    logic [4:0]   vlr;
    logic         arg_valid;
    logic         arg_ready;
    logic [127:0] arg1;
    logic [127:0] arg2;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_mask;
    logic         out_last;
    logic         busy;

    vec_logic_lanes #(
        .DATA_WIDTH (32),
        .MVL        (16),
        .LANES      (4),
        .SEGMENTS   (S),
        .ID         (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .float_op  (float_op),
        .cont_esc  (cont_esc),
        .op_esc    (op_esc),
        .mask      (mask),
        .vlr       (vlr),
        .arg_valid (arg_valid),
        .arg_ready (arg_ready),
        .arg1      (arg1),
        .arg2      (arg2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   m;
        logic         l;
    } beat_t;

    beat_t        q[$];
    logic [127:0] a1_b [4];
    logic [127:0] a2_b [4];
    logic [127:0] e_d  [4];
    logic [3:0]   e_m  [4];
    int           total = 0;
    int           bad   = 0;

    always @(negedge clk)
        if (rst_n && out_valid && out_ready) q.push_back({out_data, out_mask, out_last});

    function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 128'(obs), 128'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input op_e o, input logic f, input logic [1:0] esc,
                            input logic [31:0] sc, input logic [15:0] m, input logic [4:0] v);
        op = o; float_op = f; cont_esc = esc; op_esc = sc; mask = m; vlr = v;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int n);
        int w;
        for (int b = first; b < n; b++) begin
            arg1 = a1_b[b]; arg2 = a2_b[b]; arg_valid = 1'b1;
            w = 0;
            @(negedge clk);
            while (!arg_ready && w < 100) begin
                w++;
                @(negedge clk);
            end
            if (!arg_ready) begin
                chk1("feed_ready", arg_ready, 1'b1);
                arg_valid = 1'b0;
                step();
                return;
            end
            step();
        end
        arg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (busy && w < 300) begin
            w++;
            @(negedge clk);
        end
        chk1("idle", busy, 1'b0);
        step();
    endtask

    task automatic chk_beats(input string tag, input int n);
        chk($sformatf("%s_count", tag), 128'(q.size()), 128'(n));
        for (int i = 0; i < n && i < q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), q[i].d, e_d[i]);
            chk($sformatf("%s_mask%0d", tag, i), 128'(q[i].m), 128'(e_m[i]));
            chk1($sformatf("%s_last%0d", tag, i), q[i].l, (i == n - 1));
        end
        q.delete();
    endtask

    task automatic one_beat(input string tag, input op_e o, input logic f, input logic [4:0] v,
                            input logic [127:0] x1, input logic [127:0] x2,
                            input logic [127:0] ed, input logic [3:0] em);
        a1_b[0] = x1; a2_b[0] = x2;
        start_op(o, f, 2'b00, 32'h0, 16'hffff, v);
        feed(0, 1);
        wait_idle();
        e_d[0] = ed; e_m[0] = em;
        chk_beats(tag, 1);
    endtask

    task automatic fill_eq();
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 4; k++) begin
                a1_b[b][k*32 +: 32] = 32'h100 + 32'(b * 4 + k);
                a2_b[b][k*32 +: 32] = (k % 2 == 0) ? a1_b[b][k*32 +: 32] : (a1_b[b][k*32 +: 32] ^ 32'h40);
                e_d[b] = pack4(1, 0, 1, 0);
                e_m[b] = 4'hf;
            end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = OP_EQ; float_op = 1'b0; cont_esc = 2'b00;
        op_esc = '0; mask = '0; vlr = '0; arg_valid = 1'b0; arg1 = '0; arg2 = '0;
        out_ready = 1'b1;
        repeat (3) step();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_arg_ready", arg_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk("rst_out_mask", 128'(out_mask), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        rst_n = 1'b1;
        step();

        // vlr==0 never becomes busy
        start_op(OP_EQ, 1'b0, 2'b00, 32'h0, 16'hffff, 5'd0);
        chk1("vlr0_busy", busy, 1'b0);
        step();
        chk1("vlr0_out_valid", out_valid, 1'b0);

        // EQ vector-vector, full length
        fill_eq();
        start_op(OP_EQ, 1'b0, 2'b00, 32'h0, 16'hffff, 5'd16);
        feed(0, 4);
        wait_idle();
        chk_beats("eq", 4);

        // SLL with scalar arg1 = 3, tail in beat 1; second start while busy is ignored
        a1_b[0] = '1; a1_b[1] = '1;
        a2_b[0] = pack4(1, 2, 3, 4);
        a2_b[1] = pack4(5, 6, 99, 99);
        start_op(OP_SLL, 1'b0, 2'b10, 32'd3, 16'hffff, 5'd6);
        start_op(OP_XOR, 1'b0, 2'b00, 32'd0, 16'h0000, 5'd16);
        feed(0, 2);
        wait_idle();
        e_d[0] = pack4(8, 16, 24, 32);   e_m[0] = 4'hf;
        e_d[1] = pack4(40, 48, 0, 0);    e_m[1] = 4'h3;
        chk_beats("sll", 2);

        // SRA single beat with exact SEGMENTS latency
        a1_b[0] = pack4(4, 36, 1, 8);
        a2_b[0] = pack4(32'h80000000, 32'hfffffff0, 32'h7fffffff, 32'h100);
        start_op(OP_SRA, 1'b0, 2'b00, 32'h0, 16'hffff, 5'd4);
        arg1 = a1_b[0]; arg2 = a2_b[0]; arg_valid = 1'b1;
        @(negedge clk);
        chk1("lat_accept", arg_ready, 1'b1);
        step();
        arg_valid = 1'b0;
        for (int i = 1; i < S; i++) begin
            @(negedge clk);
            chk1($sformatf("lat_early%0d", i), out_valid, 1'b0);
            step();
        end
        @(negedge clk);
        chk1("lat_valid", out_valid, 1'b1);
        step();
        wait_idle();
        e_d[0] = pack4(32'hf8000000, 32'hffffffff, 32'h3fffffff, 32'h1); e_m[0] = 4'hf;
        chk_beats("sra", 1);

        one_beat("lt_s", OP_LT, 1'b0, 5'd4, pack4(1, 5, 32'h7fffffff, 32'h80000000),
                 pack4(32'hffffffff, 5, 32'h80000000, 32'h7fffffff), pack4(1, 0, 1, 0), 4'hf);
        one_beat("ltu", OP_LTU, 1'b0, 5'd4, pack4(1, 5, 32'h7fffffff, 32'h80000000),
                 pack4(32'hffffffff, 5, 32'h80000000, 32'h7fffffff), pack4(0, 0, 0, 1), 4'hf);
        one_beat("flt", OP_LT, 1'b1, 5'd3, pack4(32'h0, 32'h3f800000, 32'h40000000, 32'h3f800000),
                 pack4(32'h80000000, 32'h7fc00000, 32'hbf800000, 32'h0), pack4(0, 0, 1, 0), 4'h7);
        one_beat("fle", OP_LE, 1'b1, 5'd4, pack4(32'h0, 32'h3f800000, 32'hbf800000, 32'h3f800000),
                 pack4(32'h80000000, 32'h7fc00000, 32'h40000000, 32'h3f800000), pack4(1, 0, 0, 1), 4'hf);

        // Reductions over vlr=10 (three beats in, one beat out)
        for (int b = 0; b < 3; b++) begin a1_b[b] = '0; a2_b[b] = '1; end
        start_op(OP_VCPOP, 1'b0, 2'b00, 32'h0, 16'h02aa, 5'd10);
        feed(0, 3);
        wait_idle();
        e_d[0] = pack4(5, 0, 0, 0); e_m[0] = 4'h1;
        chk_beats("vcpop", 1);

        start_op(OP_VFIRST, 1'b0, 2'b00, 32'h0, 16'h0000, 5'd10);
        feed(0, 3);
        wait_idle();
        e_d[0] = pack4(32'hffffffff, 0, 0, 0); e_m[0] = 4'h1;
        chk_beats("vfirst_none", 1);

        start_op(OP_VFIRST, 1'b0, 2'b00, 32'h0, 16'h02a0, 5'd10);
        feed(0, 3);
        wait_idle();
        e_d[0] = pack4(5, 0, 0, 0); e_m[0] = 4'h1;
        chk_beats("vfirst5", 1);

        // VID consumes no operands
        start_op(OP_VID, 1'b0, 2'b00, 32'h0, 16'hffff, 5'd6);
        wait_idle();
        e_d[0] = pack4(0, 1, 2, 3); e_m[0] = 4'hf;
        e_d[1] = pack4(4, 5, 0, 0); e_m[1] = 4'h3;
        chk_beats("vid", 2);

        // Output back-pressure mid-op
        fill_eq();
        out_ready = 1'b0;
        start_op(OP_EQ, 1'b0, 2'b00, 32'h0, 16'hffff, 5'd16);
        feed(0, 1);
        repeat (S + 1) step();
        @(negedge clk);
        chk1("stall_out_valid", out_valid, 1'b1);
        step();
        arg1 = a1_b[1]; arg2 = a2_b[1]; arg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1($sformatf("stall_arg_ready%0d", i), arg_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        feed(1, 4);
        wait_idle();
        chk_beats("stall", 4);

        // Asynchronous reset while beats are still coming out
        fill_eq();
        start_op(OP_EQ, 1'b0, 2'b00, 32'h0, 16'hffff, 5'd16);
        feed(0, 4);
        for (int w = 0; w < 100 && q.size() < 2; w++) step();
        chk("rstmid_seen", 128'(q.size()), 128'(2));
        chk1("rstmid_pre_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rstmid_busy", busy, 1'b0);
        chk1("rstmid_out_valid", out_valid, 1'b0);
        chk1("rstmid_arg_ready", arg_ready, 1'b0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start_op(OP_EQ, 1'b0, 2'b00, 32'h0, 16'hffff, 5'd16);
        feed(0, 4);
        wait_idle();
        chk_beats("after_rst", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
